// File: rtl/nvm_pkg.sv
// Shared types and default constants for the NVM access controller.
// Imported by nvm_ctrl and nvm_rr_arb2.
package nvm_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    ARMED    = 2'd1,
    UNLOCKED = 2'd2
  } lock_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_PROG  = 1'b1
  } req_idx_e;

  localparam logic [31:0] KEY0_DEFAULT = 32'hA5A5_0001;
  localparam logic [31:0] KEY1_DEFAULT = 32'h5A5A_0002;

endpackage

// File: rtl/nvm_rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and the programming port.
// Grants are combinational; the pointer remembers the last winner.
module nvm_rr_arb2
  import nvm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_fetch_i,
  input  logic req_prog_i,
  output logic gnt_fetch_o,
  output logic gnt_prog_o
);

  req_idx_e last_q, last_d;

  // After reset the pointer says "prog went last", so fetch wins the first tie.
  assign gnt_fetch_o = req_fetch_i & (~req_prog_i | (last_q == REQ_PROG));
  assign gnt_prog_o  = req_prog_i & ~gnt_fetch_o;

  always_comb begin
    last_d = last_q;
    if (gnt_fetch_o) begin
      last_d = REQ_FETCH;
    end else if (gnt_prog_o) begin
      last_d = REQ_PROG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_PROG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/nvm_ctrl.sv
// NVM access controller: arbitrated fetch/programming access, registered reads,
// two-key write unlock with budget. Optional idle auto-relock: NVM_CTRL_RELOCK_TIMEOUT_EN.
module nvm_ctrl
  import nvm_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] KEY0           = DATA_WIDTH'(KEY0_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] KEY1           = DATA_WIDTH'(KEY1_DEFAULT),
  parameter int unsigned           WR_BUDGET      = 16,
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,

  input  logic                  pr_req,
  input  logic                  pr_we,
  input  logic [ADDR_WIDTH-1:0] pr_addr,
  input  logic [DATA_WIDTH-1:0] pr_wd,
  output logic                  pr_gnt,
  output logic                  pr_rvalid,
  output logic [DATA_WIDTH-1:0] pr_rdata,
  output logic                  pr_err,

  input  logic                  unlock_vld,
  input  logic [DATA_WIDTH-1:0] unlock_key,
  input  logic                  relock,
  output logic                  unlocked,

  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  lock_state_e           state_q, state_d;
  logic [31:0]           wr_cnt_q, wr_cnt_d;
  logic                  if_rvalid_q, pr_rvalid_q, pr_err_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, pr_rdata_q;
  logic                  gnt_fetch, gnt_prog;
  logic                  wr_done;
  logic                  wr_blocked;

  // Requests are masked during reset so every combinational output reads 0.
  nvm_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_fetch_i (if_req & ~rst),
    .req_prog_i  (pr_req & ~rst),
    .gnt_fetch_o (gnt_fetch),
    .gnt_prog_o  (gnt_prog)
  );

  assign if_gnt     = gnt_fetch;
  assign pr_gnt     = gnt_prog;
  assign unlocked   = (state_q == UNLOCKED);
  assign wr_done    = gnt_prog & pr_we & unlocked;
  assign wr_blocked = gnt_prog & pr_we & ~unlocked;

  assign mem_we   = wr_done;
  assign mem_addr = rst      ? '0 :
                    gnt_prog ? pr_addr : if_addr;
  assign mem_wd   = gnt_prog ? pr_wd : '0;

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign pr_rvalid = pr_rvalid_q;
  assign pr_rdata  = pr_rdata_q;
  assign pr_err    = pr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      pr_rvalid_q <= 1'b0;
      pr_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      pr_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= gnt_fetch;
      pr_rvalid_q <= gnt_prog;
      pr_err_q    <= wr_blocked;
      if (gnt_fetch) begin
        if_rdata_q <= mem_rd;
      end
      // Write acks leave the last read data untouched.
      if (gnt_prog && !pr_we) begin
        pr_rdata_q <= mem_rd;
      end
    end
  end

`ifdef NVM_CTRL_RELOCK_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        idle_expired;

  always_comb begin
    idle_d       = '0;
    idle_expired = 1'b0;
    if (state_q == UNLOCKED && !wr_done) begin
      idle_d       = idle_q + 32'd1;
      idle_expired = (idle_d == 32'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic        idle_expired;
  logic [31:0] unused_timeout;

  assign idle_expired   = 1'b0;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    unique case (state_q)
      LOCKED: begin
        if (unlock_vld && unlock_key == KEY0) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (unlock_vld) begin
          if (unlock_key == KEY1) begin
            state_d  = UNLOCKED;
            wr_cnt_d = '0;
          end else begin
            state_d = LOCKED;
          end
        end
      end
      UNLOCKED: begin
        if (wr_done) begin
          wr_cnt_d = wr_cnt_q + 32'd1;
          // The budget-exhausting write still lands; the lock closes on the same edge.
          if (WR_BUDGET != 0 && wr_cnt_d == 32'(WR_BUDGET)) begin
            state_d = LOCKED;
          end
        end
        if (idle_expired) begin
          state_d = LOCKED;
        end
      end
      default: state_d = LOCKED;
    endcase
    if (relock) begin
      state_d = LOCKED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOCKED;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

endmodule
